// File: rtl/nd_1to2_pkg.sv
// nd_1to2_pkg: shared widths, link constants and buffer-state helper for nd_1to2
package nd_1to2_pkg;
  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE = 8;
  localparam logic NS_ON = 1'b1;
  localparam logic NS_OFF = 1'b0;
  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_e;
  function automatic buf_state_e buf_state(input logic req, input logic ack);
    return (req == ack) ? BUF_EMPTY : BUF_FULL;
  endfunction
  function automatic logic bit_toggle(input logic b);
    return b ^ NS_ON;
  endfunction
endpackage

// File: rtl/nd_sync2.sv
// nd_sync2: one-bit two-flop synchronizer with async active-low clear
module nd_sync2 import nd_1to2_pkg::*; (
  input  logic i_clk,
  input  logic reset,
  input  logic d,
  output logic q1,
  output logic q
);
  always_ff @(posedge i_clk or negedge reset)
    if (!reset) {q, q1} <= {NS_OFF, NS_OFF};
    else {q, q1} <= {q1, d};
endmodule

// File: rtl/nd_1to2.sv
// nd_1to2: 2-phase link demux routing one input channel to two buffered outputs by address
module nd_1to2 import nd_1to2_pkg::*; #(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int REF_ADDR = 23
) (
  input  logic           i_clk,
  input  logic           reset,
  output logic           ready,
  input  logic [ASZ-1:0] rcv0_addr,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic           rcv0_req,
  output logic           rcv0_ack,
  output logic [ASZ-1:0] snd0_addr,
  output logic [DSZ-1:0] snd0_dat,
  output logic           snd0_req,
  input  logic           snd0_ack,
  output logic [ASZ-1:0] snd1_addr,
  output logic [DSZ-1:0] snd1_dat,
  output logic           snd1_req,
  input  logic           snd1_ack
);
  logic rq, rq_s1, a0, a0_s1, a1, a1_s1, rdy0, pending, tgt1, free0, free1, take;
  nd_sync2 u_rq (.i_clk(i_clk), .reset(reset), .d(rcv0_req), .q1(rq_s1), .q(rq));
  nd_sync2 u_a0 (.i_clk(i_clk), .reset(reset), .d(snd0_ack), .q1(a0_s1), .q(a0));
  nd_sync2 u_a1 (.i_clk(i_clk), .reset(reset), .d(snd1_ack), .q1(a1_s1), .q(a1));
  // a buffer counts as free on the edge its synced ack catches up, so it can be refilled on that same edge
  always_comb begin
    pending = (rq != rcv0_ack) && (rq_s1 == rq);
    tgt1 = rcv0_addr >= ASZ'(REF_ADDR);
    free0 = (buf_state(snd0_req, a0) == BUF_EMPTY) || (buf_state(snd0_req, a0_s1) == BUF_EMPTY);
    free1 = (buf_state(snd1_req, a1) == BUF_EMPTY) || (buf_state(snd1_req, a1_s1) == BUF_EMPTY);
    take = ready && pending && (tgt1 ? free1 : free0);
  end
  always_ff @(posedge i_clk or negedge reset)
    if (!reset) begin
      {rdy0, ready, rcv0_ack, snd0_req, snd1_req} <= '0;
      {snd0_addr, snd0_dat, snd1_addr, snd1_dat} <= '0;
    end else begin
      rdy0 <= NS_ON;
      ready <= rdy0;
      if (take) begin
        rcv0_ack <= bit_toggle(rcv0_ack);
        if (tgt1) begin
          snd1_addr <= rcv0_addr;
          snd1_dat <= rcv0_dat;
          snd1_req <= bit_toggle(snd1_req);
        end else begin
          snd0_addr <= rcv0_addr;
          snd0_dat <= rcv0_dat;
          snd0_req <= bit_toggle(snd0_req);
        end
      end
    end
endmodule

// File: tb/tb_nd_1to2.sv
// tb_nd_1to2: directed and random self-checking bench for nd_1to2
module tb_nd_1to2;
  import nd_1to2_pkg::*;
  localparam int ASZ = NS_ADDRESS_SIZE;
  localparam int DSZ = NS_DATA_SIZE;
  localparam int NMSG = 1000;
  logic i_clk = 0, clk2 = 0, reset = 0;
  logic [ASZ-1:0] rcv0_addr = '0;
  logic [DSZ-1:0] rcv0_dat = '0;
  logic rcv0_req = 0;
  logic ready, rcv0_ack, snd0_req, snd1_req, snd0_ack, snd1_ack;
  logic [ASZ-1:0] snd0_addr, snd1_addr;
  logic [DSZ-1:0] snd0_dat, snd1_dat;
  logic ack0_d = 0, ack0_r = 0, ack1_d = 0, ack1_r = 0;
  logic m_ack = 0, m_r0 = 0, m_r1 = 0;
  bit rnd_on = 0;
  int compared = 0, mismatched = 0, received = 0;
  logic [ASZ+DSZ-1:0] q0[$], q1[$];
  assign snd0_ack = ack0_d ^ ack0_r;
  assign snd1_ack = ack1_d ^ ack1_r;
  always #5 i_clk = ~i_clk;
  always #7 clk2 = ~clk2;
  nd_1to2 dut (
    .i_clk(i_clk), .reset(reset), .ready(ready),
    .rcv0_addr(rcv0_addr), .rcv0_dat(rcv0_dat), .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
    .snd0_addr(snd0_addr), .snd0_dat(snd0_dat), .snd0_req(snd0_req), .snd0_ack(snd0_ack),
    .snd1_addr(snd1_addr), .snd1_dat(snd1_dat), .snd1_req(snd1_req), .snd1_ack(snd1_ack)
  );
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  // sinks on an unrelated clock, active only during the random run
  initial forever begin
    @(negedge clk2);
    if (rnd_on && snd0_req !== snd0_ack && $urandom_range(0, 3) == 0) begin
      compared++;
      if (q0.size() == 0) begin
        mismatched++;
        $display("FAIL rnd_snd0_unexpected: got %h want none", {snd0_addr, snd0_dat});
      end else if ({snd0_addr, snd0_dat} !== q0[0]) begin
        mismatched++;
        $display("FAIL rnd_snd0_data: got %h want %h", {snd0_addr, snd0_dat}, q0[0]);
      end
      if (q0.size() != 0) void'(q0.pop_front());
      received++;
      ack0_r = ~ack0_r;
    end
  end
  initial forever begin
    @(negedge clk2);
    if (rnd_on && snd1_req !== snd1_ack && $urandom_range(0, 2) == 0) begin
      compared++;
      if (q1.size() == 0) begin
        mismatched++;
        $display("FAIL rnd_snd1_unexpected: got %h want none", {snd1_addr, snd1_dat});
      end else if ({snd1_addr, snd1_dat} !== q1[0]) begin
        mismatched++;
        $display("FAIL rnd_snd1_data: got %h want %h", {snd1_addr, snd1_dat}, q1[0]);
      end
      if (q1.size() != 0) void'(q1.pop_front());
      received++;
      ack1_r = ~ack1_r;
    end
  end
  task automatic send(input logic [ASZ-1:0] a, input logic [DSZ-1:0] d);
    @(negedge i_clk);
    rcv0_addr = a;
    rcv0_dat = d;
    rcv0_req = ~rcv0_req;
  endtask
  task automatic sink_ack(input bit ch);
    @(negedge i_clk);
    if (ch) ack1_d = ~ack1_d;
    else ack0_d = ~ack0_d;
    repeat (3) @(posedge i_clk);
  endtask
  task automatic test_route(input logic [ASZ-1:0] a, input logic [DSZ-1:0] d, input bit ack_after, input string nm);
    bit ch1;
    ch1 = a >= 23;
    send(a, d);
    repeat (2) @(posedge i_clk);
    #1;
    compared++;
    if (rcv0_ack !== m_ack) begin
      mismatched++;
      $display("FAIL %s_early_ack: got %b want %b", nm, rcv0_ack, m_ack);
    end
    @(posedge i_clk);
    #1;
    m_ack = ~m_ack;
    if (ch1) m_r1 = ~m_r1;
    else m_r0 = ~m_r0;
    compared++;
    if ({rcv0_ack, snd0_req, snd1_req} !== {m_ack, m_r0, m_r1}) begin
      mismatched++;
      $display("FAIL %s_toggles: got %b want %b", nm, {rcv0_ack, snd0_req, snd1_req}, {m_ack, m_r0, m_r1});
    end
    compared++;
    if ((ch1 ? {snd1_addr, snd1_dat} : {snd0_addr, snd0_dat}) !== {a, d}) begin
      mismatched++;
      $display("FAIL %s_payload: got %h want %h", nm, ch1 ? {snd1_addr, snd1_dat} : {snd0_addr, snd0_dat}, {a, d});
    end
    if (ack_after) sink_ack(ch1);
  endtask
  task automatic test_reset;
    #1;
    compared++;
    if ({ready, rcv0_ack, snd0_req, snd1_req, snd0_addr, snd0_dat, snd1_addr, snd1_dat} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want 0", {ready, rcv0_ack, snd0_req, snd1_req, snd0_addr, snd0_dat, snd1_addr, snd1_dat});
    end
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    #2 reset = 1;
    @(posedge i_clk);
    #1;
    compared++;
    if (ready !== 1'b0) begin
      mismatched++;
      $display("FAIL ready_edge1: got %b want 0", ready);
    end
    @(posedge i_clk);
    #1;
    compared++;
    if ({ready, rcv0_ack, snd0_req, snd1_req} !== 4'b1000) begin
      mismatched++;
      $display("FAIL ready_edge2: got %b want 1000", {ready, rcv0_ack, snd0_req, snd1_req});
    end
  endtask
  task automatic test_routing;
    test_route(22, 5, 1, "a22");
    test_route(23, 9, 1, "a23");
    test_route(55, 3, 1, "a55");
    test_route(0, 8'hA5, 1, "a0");
    test_route('1, 8'h3C, 1, "aones");
  endtask
  task automatic test_stall;
    test_route(10, 1, 0, "stall_first");
    send(11, 2);
    repeat (6) @(posedge i_clk);
    #1;
    compared++;
    if ({rcv0_ack, snd0_req, snd0_addr, snd0_dat} !== {m_ack, m_r0, 8'd10, 8'd1}) begin
      mismatched++;
      $display("FAIL stall_hold: got %h want %h", {rcv0_ack, snd0_req, snd0_addr, snd0_dat}, {m_ack, m_r0, 8'd10, 8'd1});
    end
    @(negedge i_clk);
    ack0_d = ~ack0_d;
    @(posedge i_clk);
    #1;
    compared++;
    if ({rcv0_ack, snd0_addr} !== {m_ack, 8'd10}) begin
      mismatched++;
      $display("FAIL stall_free_edge1: got %h want %h", {rcv0_ack, snd0_addr}, {m_ack, 8'd10});
    end
    @(posedge i_clk);
    #1;
    m_ack = ~m_ack;
    m_r0 = ~m_r0;
    compared++;
    if ({rcv0_ack, snd0_req, snd0_addr, snd0_dat} !== {m_ack, m_r0, 8'd11, 8'd2}) begin
      mismatched++;
      $display("FAIL stall_second: got %h want %h", {rcv0_ack, snd0_req, snd0_addr, snd0_dat}, {m_ack, m_r0, 8'd11, 8'd2});
    end
    sink_ack(0);
  endtask
  task automatic test_other_channel;
    test_route(5, 3, 0, "blk_snd0");
    test_route(40, 7, 1, "blk_snd1");
    compared++;
    if ({snd0_req, snd0_addr, snd0_dat} !== {m_r0, 8'd5, 8'd3}) begin
      mismatched++;
      $display("FAIL blk_snd0_held: got %h want %h", {snd0_req, snd0_addr, snd0_dat}, {m_r0, 8'd5, 8'd3});
    end
    sink_ack(0);
    test_route(41, 6, 1, "blk_after");
  endtask
  task automatic test_reset_mid;
    test_route(1, 1, 0, "mid_snd0");
    test_route(50, 4, 0, "mid_snd1");
    send(2, 2);
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    #2 reset = 0;
    #1;
    compared++;
    if ({ready, rcv0_ack, snd0_req, snd1_req, snd0_addr, snd0_dat, snd1_addr, snd1_dat} !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_outputs: got %h want 0", {ready, rcv0_ack, snd0_req, snd1_req, snd0_addr, snd0_dat, snd1_addr, snd1_dat});
    end
    rcv0_req = 0;
    ack0_d = 0;
    ack1_d = 0;
    {m_ack, m_r0, m_r1} = '0;
    repeat (2) @(posedge i_clk);
    #3 reset = 1;
    @(posedge i_clk);
    #1;
    compared++;
    if ({ready, rcv0_ack, snd0_req, snd1_req} !== 4'b0000) begin
      mismatched++;
      $display("FAIL mid_release_edge1: got %b want 0000", {ready, rcv0_ack, snd0_req, snd1_req});
    end
    repeat (3) @(posedge i_clk);
    #1;
    compared++;
    if ({ready, rcv0_ack, snd0_req, snd1_req} !== 4'b1000) begin
      mismatched++;
      $display("FAIL mid_release_quiet: got %b want 1000", {ready, rcv0_ack, snd0_req, snd1_req});
    end
    test_route(30, 8, 1, "mid_a30");
  endtask
  task automatic test_random;
    logic [ASZ-1:0] a;
    logic [DSZ-1:0] d;
    int t;
    rnd_on = 1;
    for (int i = 0; i < NMSG; i++) begin
      t = 0;
      while (rcv0_ack !== rcv0_req && t < 1000) begin
        @(negedge i_clk);
        t++;
      end
      if (t >= 1000) begin
        compared++;
        mismatched++;
        $display("FAIL rnd_input_stuck: got pending at msg %0d want accepted", i);
        break;
      end
      @(negedge i_clk);
      a = ASZ'($urandom_range(0, (1 << ASZ) - 1));
      d = DSZ'($urandom);
      if (a >= 23) q1.push_back({a, d});
      else q0.push_back({a, d});
      rcv0_addr = a;
      rcv0_dat = d;
      rcv0_req = ~rcv0_req;
    end
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || rcv0_ack !== rcv0_req) && t < 2000) begin
      @(negedge i_clk);
      t++;
    end
    repeat (10) @(negedge i_clk);
    rnd_on = 0;
    compared++;
    if (received != NMSG || q0.size() != 0 || q1.size() != 0) begin
      mismatched++;
      $display("FAIL rnd_count: got %0d delivered (%0d/%0d left) want %0d", received, q0.size(), q1.size(), NMSG);
    end
    compared++;
    if (snd0_req !== snd0_ack || snd1_req !== snd1_ack) begin
      mismatched++;
      $display("FAIL rnd_idle: got %b want both links idle", {snd0_req, snd0_ack, snd1_req, snd1_ack});
    end
  endtask
  initial begin
    test_reset;
    test_routing;
    test_stall;
    test_other_channel;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
